// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg -- shared definitions for the 4-requester round-robin arbiter.
//   arb_state_t : FSM state encodings (IDLE, GRANT, GAP; 2'b11 is unused)
//   NUM_REQ     : number of requesters
//   ID_W        : width of a requester index
//   rr_pick     : round-robin search returning {found, winner_index}
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } arb_state_t;

  // Search starts one past the last grantee and wraps, so the last grantee
  // is the lowest priority. Offsets are visited from farthest to nearest so
  // that the nearest active requester is the final (winning) assignment.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/dec2to4_l.sv
// -----------------------------------------------------------------------------
// dec2to4_l -- 2-to-4 decoder, active-low enable and active-low outputs.
//   i_en_l  : enable, active-low; when high all outputs are high
//   i_sel   : 2-bit select
//   o_dec_l : 4-bit one-cold output (bit i_sel low when enabled)
// -----------------------------------------------------------------------------
module dec2to4_l
  import arb_pkg::*;
(
  input  logic               i_en_l,
  input  logic [ID_W-1:0]    i_sel,
  output logic [NUM_REQ-1:0] o_dec_l
);

  always_comb begin
    o_dec_l = '1;
    if (!i_en_l) o_dec_l[i_sel] = 1'b0;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4 -- 4-requester round-robin arbiter with bounded hold time and a
// one-cycle dead time between grants.
//   MAX_HOLD : maximum consecutive cycles one grant is held (2..255)
//   CLK      : clock, rising edge
//   RST_L    : asynchronous active-low reset
//   EN_L     : active-low arbiter enable
//   REQ_L    : active-low requests, bit i = requester i
//   GNT_L    : registered active-low grants, at most one bit low
//   GNT_ID   : index of the current grantee (meaningful while BUSY=1)
//   BUSY     : high while a grant is asserted
// -----------------------------------------------------------------------------
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               CLK,
  input  logic               RST_L,
  input  logic               EN_L,
  input  logic [NUM_REQ-1:0] REQ_L,
  output logic [NUM_REQ-1:0] GNT_L,
  output logic [ID_W-1:0]    GNT_ID,
  output logic               BUSY
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [7:0]          r_hold;
  logic                r_run;
  logic [NUM_REQ-1:0]  r_gnt_l;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_busy;

  arb_state_t          w_state_nxt;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [7:0]          w_hold_nxt;
  logic [ID_W-1:0]     w_id_nxt;
  logic                w_busy_nxt;
  logic [ID_W:0]       w_pick;
  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_dec_l;

  assign w_req  = ~REQ_L;
  assign w_pick = rr_pick(w_req, r_ptr);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_id_nxt    = r_gnt_id;
    w_busy_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        // r_run keeps the first edge after reset release as a pure wake-up edge.
        if (r_run && !EN_L && w_pick[ID_W]) begin
          w_state_nxt = GRANT;
          w_id_nxt    = w_pick[ID_W-1:0];
          w_ptr_nxt   = w_pick[ID_W-1:0];
          w_hold_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (EN_L) begin
          w_state_nxt = IDLE;
        end else if (!REQ_L[r_gnt_id] && (r_hold < HOLD_LAST)) begin
          w_hold_nxt = r_hold + 8'd1;
          w_busy_nxt = 1'b1;
        end else begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (EN_L || !w_pick[ID_W]) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GRANT;
          w_id_nxt    = w_pick[ID_W-1:0];
          w_ptr_nxt   = w_pick[ID_W-1:0];
          w_hold_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  dec2to4_l u_dec (
    .i_en_l  (~w_busy_nxt),
    .i_sel   (w_id_nxt),
    .o_dec_l (w_dec_l)
  );

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_state  <= IDLE;
      r_ptr    <= 2'b11;
      r_hold   <= '0;
      r_run    <= 1'b0;
      r_gnt_l  <= '1;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_run    <= 1'b1;
      r_gnt_l  <= w_dec_l;
      r_gnt_id <= w_id_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign GNT_L  = r_gnt_l;
  assign GNT_ID = r_gnt_id;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_4 -- directed bench for rr_arbiter_4. Instance a uses
// MAX_HOLD=3, instance b uses MAX_HOLD=4.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_a, en_a, rst_b, en_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter_4 #(.MAX_HOLD(3)) dut_a (
    .CLK(clk), .RST_L(rst_a), .EN_L(en_a), .REQ_L(req_a),
    .GNT_L(gnt_a), .GNT_ID(id_a), .BUSY(busy_a)
  );

  rr_arbiter_4 #(.MAX_HOLD(4)) dut_b (
    .CLK(clk), .RST_L(rst_b), .EN_L(en_b), .REQ_L(req_b),
    .GNT_L(gnt_b), .GNT_ID(id_b), .BUSY(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check grant vector, BUSY, and GNT_ID when a grant is expected.
  task automatic chk_a(input string tag, input logic [3:0] eg, input logic eb, input logic [1:0] eid);
    chk({tag, " gnt_a"}, 32'(gnt_a), 32'(eg));
    chk({tag, " busy_a"}, 32'(busy_a), 32'(eb));
    if (eb) chk({tag, " id_a"}, 32'(id_a), 32'(eid));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] eg, input logic eb, input logic [1:0] eid);
    chk({tag, " gnt_b"}, 32'(gnt_b), 32'(eg));
    chk({tag, " busy_b"}, 32'(busy_b), 32'(eb));
    if (eb) chk({tag, " id_b"}, 32'(id_b), 32'(eid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] g;
    rst_a = 1'b0; rst_b = 1'b0;
    en_a  = 1'b1; en_b  = 1'b1;
    req_a = 4'hF; req_b = 4'hF;

    // Reset state while RST_L is held low across edges
    #12;
    chk_a("reset", 4'hF, 1'b0, 2'd0);
    chk("reset id_a", 32'(id_a), 32'd0);
    chk_b("reset", 4'hF, 1'b0, 2'd0);
    chk("reset id_b", 32'(id_b), 32'd0);
    #11;                       // t=23, between edges
    rst_a = 1'b1; rst_b = 1'b1;

    // Enabled with no requests: stays idle
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_a("noreq", 4'hF, 1'b0, 2'd0);
    end

    // All request, MAX_HOLD=3: order 0,1,2,3,0, 3 cycles each, 1-cycle gap
    req_a = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      g = 4'hF;
      g[k % 4] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_a($sformatf("rr k%0d c%0d", k, c), g, 1'b1, 2'(k % 4));
      end
      if (k < 4) begin
        tick();
        chk_a($sformatf("rr gap%0d", k), 4'hF, 1'b0, 2'd0);
      end
    end
    req_a = 4'hF;
    tick(); chk_a("rr end gap", 4'hF, 1'b0, 2'd0);
    tick(); chk_a("rr end idle", 4'hF, 1'b0, 2'd0);

    // Only requester 2, releasing after two grant cycles
    req_a = 4'b1011;
    tick(); chk_a("r2 c0", 4'b1011, 1'b1, 2'd2);
    tick(); chk_a("r2 c1", 4'b1011, 1'b1, 2'd2);
    req_a = 4'hF;
    tick(); chk_a("r2 gap", 4'hF, 1'b0, 2'd0);
    tick(); chk_a("r2 idle0", 4'hF, 1'b0, 2'd0);
    tick(); chk_a("r2 idle1", 4'hF, 1'b0, 2'd0);

    // EN_L pulse during grant to 3; afterwards 0 beats 3
    req_a = 4'b0111;
    tick(); chk_a("en g3", 4'b0111, 1'b1, 2'd3);
    en_a = 1'b1;
    tick(); chk_a("en off", 4'hF, 1'b0, 2'd0);
    en_a = 1'b0; req_a = 4'b0000;
    tick(); chk_a("en back g0", 4'b1110, 1'b1, 2'd0);
    req_a = 4'hF;
    tick(); chk_a("en rel gap", 4'hF, 1'b0, 2'd0);
    tick(); chk_a("en rel idle", 4'hF, 1'b0, 2'd0);

    // Async reset mid-grant: grant drops without a clock; PTR back to 3
    req_a = 4'b0000;
    tick(); chk_a("rst g1 c0", 4'b1101, 1'b1, 2'd1);
    tick(); chk_a("rst g1 c1", 4'b1101, 1'b1, 2'd1);
    #3 rst_a = 1'b0;
    #1 chk_a("rst async", 4'hF, 1'b0, 2'd0);
    chk("rst async id_a", 32'(id_a), 32'd0);
    #2 rst_a = 1'b1;
    tick(); chk_a("rst wake", 4'hF, 1'b0, 2'd0);
    tick(); chk_a("rst first g0", 4'b1110, 1'b1, 2'd0);
    req_a = 4'hF;
    en_a  = 1'b1;

    // Requester 1 alone with MAX_HOLD=4: forced release, gap, regrant
    en_b  = 1'b0;
    req_b = 4'b1101;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_b($sformatf("mh4 c%0d", c), 4'b1101, 1'b1, 2'd1);
    end
    tick(); chk_b("mh4 gap", 4'hF, 1'b0, 2'd0);
    tick(); chk_b("mh4 regrant", 4'b1101, 1'b1, 2'd1);
    req_b = 4'hF;
    en_b  = 1'b1;
    tick(); chk_b("mh4 off", 4'hF, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
